fir_wb_sample_buffer: RTL and testbench
=======================================

# fir_wb_sample_buffer

Wishbone-slave sample buffer between the AXI4-Lite-to-Wishbone bridge and the FIR filter datapath. Software writes input samples into an input FIFO and reads filtered results from an output FIFO. Both FIFOs connect to the filter over valid/ready streams. Sticky error flags and a level interrupt report FIFO status to the processor.

## Interface
- ADDR_W, 32, Wishbone address width; only wb_adr_i[4:2] is decoded.
- SAMPLE_W, 32, sample width on both streams (≤ 32); zero-extended on reads.
- DEPTH, 16, entries per FIFO; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counters.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_adr_i  in  ADDR_W  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data; valid while wb_ack_o=1.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  single-cycle error; replaces the ack.
- int_o  out  1  level interrupt.
- fir_in_data_o  out  SAMPLE_W  head of the input FIFO.
- fir_in_valid_o  out  1  input sample valid.
- fir_in_ready_i  in  1  filter accepts the sample.
- fir_out_data_i  in  SAMPLE_W  filtered sample.
- fir_out_valid_i  in  1  filtered sample valid.
- fir_out_ready_o  out  1  buffer accepts the filtered sample.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL, RW: bit0 EN; bit1 FLUSH, self-clearing, reads 0; bit2 INT_EN.
  - 0x04 STATUS, RO: [7:0] in_count; [15:8] out_count; 16 in_full; 17 in_empty; 18 out_full; 19 out_empty; 20 OVF; 21 UDF.
  - 0x08 DIN, WO: push wb_dat_i[SAMPLE_W-1:0] into the input FIFO. Reads return 0.
  - 0x0C DOUT, RO: pop the output FIFO. Writes are ignored.
  - 0x10 CLR, W1C: bit20 clears OVF; bit21 clears UDF.
- Unmapped offsets: acked; reads return 0; writes are ignored.
- A DIN write with wb_sel_i ≠ 4'hF gets wb_err_o instead of wb_ack_o. No push occurs.
- Request acceptance: cyc & stb & !ack & !err. Side effects (push, pop, CTRL update, W1C) happen on the accepting edge, exactly once per transaction.
- Push while in_full: sample dropped, OVF set.
- Pop while out_empty: reads 0, UDF set.
- Input stream: fir_in_valid_o = EN & !in_empty. fir_in_data_o is the combinational head entry. The FIFO pops on valid & ready.
- Output stream: fir_out_ready_o = EN & !out_full. The FIFO pushes on valid & ready. Backpressure is lossless.
- Full/empty decisions use pre-edge state:
  - A software push to a full FIFO is dropped even if the filter pops in the same cycle.
  - A software pop from an empty FIFO underflows even if the filter pushes in the same cycle.
  - Non-boundary simultaneous push and pop both succeed; the count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts saturate structurally at DEPTH.
- FLUSH=1 write: on the same edge, clears both FIFOs' pointers and counts. It overrides any same-edge stream transfer. OVF, UDF, EN and INT_EN are not affected by FLUSH; they take the values written to CTRL.
- int_o is registered: INT_EN & (!out_empty | OVF | UDF).

## Timing
- Reset values (async): wb_ack_o=0, wb_err_o=0, wb_dat_o=0, int_o=0, fir_in_valid_o=0, fir_out_ready_o=0, fir_in_data_o=0. CTRL=0, OVF=UDF=0, all pointers and counts 0.
- Bus latency: ack/err is registered one cycle after acceptance and lasts one cycle. Back-to-back requests therefore take 2 cycles each.
- Read data is registered together with the ack, so a DOUT read shows the pre-pop head.
- Status visibility: STATUS and stream flags reflect a push or pop on the cycle after the edge that performed it. int_o lags one further cycle.
- An input FIFO push becomes visible on fir_in_valid_o on the next cycle; there is no write-through.
- Reset asserted mid-transaction: ack/err are cleared immediately and the transaction is abandoned. The master must retry.

## Test plan
- Reset, then EN=1; push 0x11, 0x22, 0x33 with fir_in_ready_i=1 -> fir_in_data_o shows 0x11, 0x22, 0x33 on consecutive valid cycles; in_count returns to 0.
- EN=1, fir_in_ready_i=0, push 17 samples with DEPTH=16 -> in_full=1, in_count=16, OVF=1; sample 17 never appears. Writing 0x0010_0000 to CLR -> OVF=0.
- Filter drives 0xA5 and 0x5A -> DOUT reads return 0xA5, then 0x5A, then 0 with UDF=1. INT_EN=1 -> int_o high while out_count>0 and while UDF is set.
- Fill the input FIFO, then on the same cycle push from the bus and pop from the filter -> bus push dropped, OVF=1, in_count=15. Repeat at count 8 -> count stays 8 and no flag is set.
- Partial-select DIN write (wb_sel_i=4'h3) -> wb_err_o pulses, wb_ack_o stays 0, in_count unchanged.
- Fill both FIFOs, write CTRL=0x3 -> next cycle both counts are 0, in_empty=1, out_empty=1, EN=1. Assert wb_rst_i mid-write -> all outputs are 0 in the same cycle.

Source files
------------

// File: rtl/fir_wb_sample_buffer_if.sv
// ---------------------------------------------------------------------------
// fir_wb_sample_buffer_if
//
// Bundles the Wishbone slave bus and the two FIR valid/ready streams of the
// sample buffer.
//
// Signals (named from the buffer's point of view):
//   wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i  bus request
//   wb_dat_o/wb_ack_o/wb_err_o                           bus response
//   fir_in_data_o/fir_in_valid_o/fir_in_ready_i          samples to filter
//   fir_out_data_i/fir_out_valid_i/fir_out_ready_o       results from filter
//
// Modports:
//   slave  - the sample buffer
//   master - the bus master / filter side (testbench)
// ---------------------------------------------------------------------------
interface fir_wb_sample_buffer_if #(
    parameter int ADDR_W   = 32,
    parameter int SAMPLE_W = 32
);
    logic [ADDR_W-1:0]   wb_adr_i;
    logic [31:0]         wb_dat_i;
    logic [3:0]          wb_sel_i;
    logic                wb_we_i;
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic [31:0]         wb_dat_o;
    logic                wb_ack_o;
    logic                wb_err_o;

    logic [SAMPLE_W-1:0] fir_in_data_o;
    logic                fir_in_valid_o;
    logic                fir_in_ready_i;
    logic [SAMPLE_W-1:0] fir_out_data_i;
    logic                fir_out_valid_i;
    logic                fir_out_ready_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output fir_in_data_o, fir_in_valid_o,
        input  fir_in_ready_i,
        input  fir_out_data_i, fir_out_valid_i,
        output fir_out_ready_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  fir_in_data_o, fir_in_valid_o,
        output fir_in_ready_i,
        output fir_out_data_i, fir_out_valid_i,
        input  fir_out_ready_o
    );
endinterface

// File: rtl/fir_wb_sample_buffer.sv
// ---------------------------------------------------------------------------
// fir_wb_sample_buffer
//
// Wishbone slave sample buffer in front of the FIR datapath. Software pushes
// samples into an input FIFO (DIN) that drains to the filter over a
// valid/ready stream, and pops filtered results from an output FIFO (DOUT)
// that the filter fills over a second stream. Sticky OVF/UDF flags and a
// registered level interrupt report FIFO status.
//
// Register map (byte offsets, adr[4:2] decoded):
//   0x00 CTRL   RW  bit0 EN, bit1 FLUSH (self-clearing, reads 0), bit2 INT_EN
//   0x04 STATUS RO  [7:0] in_count, [15:8] out_count, 16 in_full,
//                   17 in_empty, 18 out_full, 19 out_empty, 20 OVF, 21 UDF
//   0x08 DIN    WO  push sample (full-word select only, else error)
//   0x0C DOUT   RO  pop result (0 and UDF when empty)
//   0x10 CLR    W1C bit20 clears OVF, bit21 clears UDF
//
// Ports:
//   wb_clk_i  clock for the whole block
//   wb_rst_i  asynchronous active-high reset
//   bus       Wishbone slave + FIR streams (fir_wb_sample_buffer_if.slave)
//   int_o     level interrupt: INT_EN & (!out_empty | OVF | UDF), registered
// ---------------------------------------------------------------------------
module fir_wb_sample_buffer #(
    parameter int ADDR_W   = 32,
    parameter int SAMPLE_W = 32,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    fir_wb_sample_buffer_if.slave  bus,
    output logic                   int_o
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_DIN    = 3'd2;
    localparam logic [2:0] OFF_DOUT   = 3'd3;
    localparam logic [2:0] OFF_CLR    = 3'd4;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [31:0] zext_sample(input logic [SAMPLE_W-1:0] s);
        logic [31:0] v;
        v = '0;
        v[SAMPLE_W-1:0] = s;
        return v;
    endfunction

    function automatic logic [7:0] cnt_field(input logic [CNT_W-1:0] c);
        return 8'(c);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec);
        case ({inc, dec})
            2'b10:   return c + CNT_ONE;
            2'b01:   return c - CNT_ONE;
            default: return c;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                r_ack;
    logic                r_err;
    logic [31:0]         r_dat;
    logic                r_int;
    logic                r_en;
    logic                r_int_en;
    logic                r_ovf;
    logic                r_udf;

    logic [PTR_W-1:0]    r_in_wptr;
    logic [PTR_W-1:0]    r_in_rptr;
    logic [CNT_W-1:0]    r_in_cnt;
    logic [PTR_W-1:0]    r_out_wptr;
    logic [PTR_W-1:0]    r_out_rptr;
    logic [CNT_W-1:0]    r_out_cnt;

    logic [SAMPLE_W-1:0] r_in_mem  [DEPTH];
    logic [SAMPLE_W-1:0] r_out_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic                w_accept;
    logic [2:0]          w_off;
    logic                w_full_sel;
    logic                w_din_err;
    logic                w_sw_push_req;
    logic                w_sw_pop_req;
    logic                w_ctrl_wr;
    logic                w_clr_wr;
    logic                w_flush;

    // A request is taken only while no response is pending, so a master that
    // keeps cyc/stb high through its ack cannot trigger a second side effect.
    assign w_accept      = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack & ~r_err;
    assign w_off         = bus.wb_adr_i[4:2];
    assign w_full_sel    = (bus.wb_sel_i == 4'hF);
    assign w_din_err     = w_accept & bus.wb_we_i & (w_off == OFF_DIN) & ~w_full_sel;
    assign w_sw_push_req = w_accept & bus.wb_we_i & (w_off == OFF_DIN) & w_full_sel;
    assign w_sw_pop_req  = w_accept & ~bus.wb_we_i & (w_off == OFF_DOUT);
    assign w_ctrl_wr     = w_accept & bus.wb_we_i & (w_off == OFF_CTRL);
    assign w_clr_wr      = w_accept & bus.wb_we_i & (w_off == OFF_CLR);
    assign w_flush       = w_ctrl_wr & bus.wb_dat_i[1];

    // Address bits outside [4:2] and unused data bits are don't-care.
    logic w_unused;
    assign w_unused = ^{bus.wb_adr_i, bus.wb_dat_i};

    // -----------------------------------------------------------------------
    // FIFO status and transfers (all decisions on pre-edge state)
    // -----------------------------------------------------------------------
    logic                w_in_full;
    logic                w_in_empty;
    logic                w_out_full;
    logic                w_out_empty;
    logic                w_in_valid;
    logic                w_out_ready;
    logic                w_in_push;
    logic                w_in_pop;
    logic                w_out_push;
    logic                w_out_pop;
    logic [SAMPLE_W-1:0] w_in_head;
    logic [SAMPLE_W-1:0] w_out_head;

    assign w_in_full   = (r_in_cnt == CNT_FULL);
    assign w_in_empty  = (r_in_cnt == '0);
    assign w_out_full  = (r_out_cnt == CNT_FULL);
    assign w_out_empty = (r_out_cnt == '0);

    assign w_in_valid  = r_en & ~w_in_empty;
    assign w_out_ready = r_en & ~w_out_full;

    assign w_in_push   = w_sw_push_req & ~w_in_full;
    assign w_in_pop    = w_in_valid & bus.fir_in_ready_i;
    assign w_out_push  = bus.fir_out_valid_i & w_out_ready;
    assign w_out_pop   = w_sw_pop_req & ~w_out_empty;

    // Heads read as zero when empty: keeps the stream data at 0 out of reset
    // and gives the DOUT underflow read its 0 without extra muxing.
    assign w_in_head   = w_in_empty  ? '0 : r_in_mem[r_in_rptr];
    assign w_out_head  = w_out_empty ? '0 : r_out_mem[r_out_rptr];

    assign bus.fir_in_data_o   = w_in_head;
    assign bus.fir_in_valid_o  = w_in_valid;
    assign bus.fir_out_ready_o = w_out_ready;

    // -----------------------------------------------------------------------
    // Read data mux
    // -----------------------------------------------------------------------
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_status = {10'b0, r_udf, r_ovf,
                       w_out_empty, w_out_full, w_in_empty, w_in_full,
                       cnt_field(r_out_cnt), cnt_field(r_in_cnt)};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:   w_rdata = {29'b0, r_int_en, 1'b0, r_en};
            OFF_STATUS: w_rdata = w_status;
            OFF_DOUT:   w_rdata = zext_sample(w_out_head);
            default:    w_rdata = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Bus response, control and flags
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
            r_int    <= 1'b0;
            r_en     <= 1'b0;
            r_int_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_ack <= w_accept & ~w_din_err;
            r_err <= w_din_err;
            r_dat <= (w_accept & ~bus.wb_we_i) ? w_rdata : '0;
            r_int <= r_int_en & (~w_out_empty | r_ovf | r_udf);

            if (w_ctrl_wr) begin
                r_en     <= bus.wb_dat_i[0];
                r_int_en <= bus.wb_dat_i[2];
            end

            if (w_sw_push_req & w_in_full) begin
                r_ovf <= 1'b1;
            end else if (w_clr_wr & bus.wb_dat_i[20]) begin
                r_ovf <= 1'b0;
            end

            if (w_sw_pop_req & w_out_empty) begin
                r_udf <= 1'b1;
            end else if (w_clr_wr & bus.wb_dat_i[21]) begin
                r_udf <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and counts; FLUSH beats any same-edge stream transfer
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_in_wptr  <= '0;
            r_in_rptr  <= '0;
            r_in_cnt   <= '0;
            r_out_wptr <= '0;
            r_out_rptr <= '0;
            r_out_cnt  <= '0;
        end else if (w_flush) begin
            r_in_wptr  <= '0;
            r_in_rptr  <= '0;
            r_in_cnt   <= '0;
            r_out_wptr <= '0;
            r_out_rptr <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_in_push)  r_in_wptr  <= r_in_wptr + PTR_ONE;
            if (w_in_pop)   r_in_rptr  <= r_in_rptr + PTR_ONE;
            if (w_out_push) r_out_wptr <= r_out_wptr + PTR_ONE;
            if (w_out_pop)  r_out_rptr <= r_out_rptr + PTR_ONE;
            r_in_cnt  <= cnt_next(r_in_cnt,  w_in_push,  w_in_pop);
            r_out_cnt <= cnt_next(r_out_cnt, w_out_push, w_out_pop);
        end
    end

    // Storage is not reset; the empty-gated heads hide stale contents.
    always_ff @(posedge wb_clk_i) begin
        if (w_in_push) begin
            r_in_mem[r_in_wptr] <= bus.wb_dat_i[SAMPLE_W-1:0];
        end
        if (w_out_push) begin
            r_out_mem[r_out_wptr] <= bus.fir_out_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.wb_ack_o = r_ack;
    assign bus.wb_err_o = r_err;
    assign bus.wb_dat_o = r_dat;
    assign int_o        = r_int;

endmodule

// File: tb/tb_fir_wb_sample_buffer.sv
module tb_fir_wb_sample_buffer;

    localparam int ADDR_W   = 32;
    localparam int SAMPLE_W = 32;
    localparam int DEPTH    = 16;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_DIN    = 32'h08;
    localparam logic [31:0] A_DOUT   = 32'h0C;
    localparam logic [31:0] A_CLR    = 32'h10;
    localparam logic [31:0] A_UNMAP  = 32'h14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic int_o;

    int n_cmp = 0;
    int n_bad = 0;

    fir_wb_sample_buffer_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) bus ();

    fir_wb_sample_buffer #(
        .ADDR_W   (ADDR_W),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .int_o    (int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction, entered and left at #1 after a rising edge with no
    // response pending, so the request is taken on the first edge. With
    // pulse_rdy the filter-side ready is raised for exactly that edge.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic pulse_rdy,
                        output logic [31:0] rdat, output logic ack, output logic err);
        int n;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        if (pulse_rdy) bus.fir_in_ready_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (pulse_rdy) bus.fir_in_ready_i = 1'b0;
        end while (!(bus.wb_ack_o | bus.wb_err_o) && n < 8);
        rdat = bus.wb_dat_o;
        ack  = bus.wb_ack_o;
        err  = bus.wb_err_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        logic a, e;
        xfer(1'b1, adr, dat, 4'hF, 1'b0, d, a, e);
        check("wr_ack", {31'b0, a}, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        logic a, e;
        xfer(1'b0, adr, 32'h0, 4'hF, 1'b0, d, a, e);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic a, e;

        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.fir_in_ready_i  = 1'b0;
        bus.fir_out_data_i  = '0;
        bus.fir_out_valid_i = 1'b0;

        // Reset state
        #2;
        check("rst_ack",       {31'b0, bus.wb_ack_o},        32'd0);
        check("rst_err",       {31'b0, bus.wb_err_o},        32'd0);
        check("rst_dat",       bus.wb_dat_o,                 32'd0);
        check("rst_int",       {31'b0, int_o},               32'd0);
        check("rst_in_valid",  {31'b0, bus.fir_in_valid_o},  32'd0);
        check("rst_out_ready", {31'b0, bus.fir_out_ready_o}, 32'd0);
        check("rst_in_data",   bus.fir_in_data_o,            32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("rst_status", A_STATUS, 32'h000A_0000);

        // Input stream ordering
        wr(A_CTRL, 32'h1);
        rd_chk("ctrl_en", A_CTRL, 32'h1);
        wr(A_DIN, 32'h11);
        wr(A_DIN, 32'h22);
        wr(A_DIN, 32'h33);
        check("s1_valid", {31'b0, bus.fir_in_valid_o}, 32'd1);
        check("s1_d0", bus.fir_in_data_o, 32'h11);
        bus.fir_in_ready_i = 1'b1;
        @(posedge clk); #1;
        check("s1_d1", bus.fir_in_data_o, 32'h22);
        @(posedge clk); #1;
        check("s1_d2", bus.fir_in_data_o, 32'h33);
        @(posedge clk); #1;
        check("s1_drained", {31'b0, bus.fir_in_valid_o}, 32'd0);
        bus.fir_in_ready_i = 1'b0;
        rd_chk("s1_status", A_STATUS, 32'h000A_0000);

        // Overflow on 17th push, W1C clear, sample 17 never appears
        for (int i = 0; i < 17; i++) wr(A_DIN, 32'h100 + i);
        rd_chk("ovf_status", A_STATUS, 32'h0019_0010);
        wr(A_CLR, 32'h0010_0000);
        rd_chk("ovf_clr_status", A_STATUS, 32'h0009_0010);
        bus.fir_in_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_data", bus.fir_in_data_o, 32'h100 + i);
            @(posedge clk); #1;
        end
        check("ovf_drain_empty", {31'b0, bus.fir_in_valid_o}, 32'd0);
        bus.fir_in_ready_i = 1'b0;

        // Output FIFO, DOUT pops, underflow, interrupt
        wr(A_CTRL, 32'h5);
        check("out_ready", {31'b0, bus.fir_out_ready_o}, 32'd1);
        bus.fir_out_valid_i = 1'b1;
        bus.fir_out_data_i  = 32'hA5;
        @(posedge clk); #1;
        bus.fir_out_data_i  = 32'h5A;
        @(posedge clk); #1;
        bus.fir_out_valid_i = 1'b0;
        check("int_out_nonempty", {31'b0, int_o}, 32'd1);
        rd_chk("dout_a5", A_DOUT, 32'hA5);
        rd_chk("dout_5a", A_DOUT, 32'h5A);
        check("int_out_empty", {31'b0, int_o}, 32'd0);
        rd_chk("dout_udf", A_DOUT, 32'h0);
        check("int_udf", {31'b0, int_o}, 32'd1);
        rd_chk("udf_status", A_STATUS, 32'h002A_0000);
        rd_chk("ctrl_flush_reads0", A_CTRL, 32'h5);
        wr(A_CLR, 32'h0020_0000);
        check("int_udf_cleared", {31'b0, int_o}, 32'd0);

        // Simultaneous bus push and filter pop at full, then at count 8
        for (int i = 0; i < 16; i++) wr(A_DIN, 32'h200 + i);
        xfer(1'b1, A_DIN, 32'hBAD, 4'hF, 1'b1, d, a, e);
        check("full_pp_ack", {31'b0, a}, 32'd1);
        check("int_ovf", {31'b0, int_o}, 32'd1);
        rd_chk("full_pp_status", A_STATUS, 32'h0018_000F);
        check("full_pp_head", bus.fir_in_data_o, 32'h201);
        wr(A_CLR, 32'h0010_0000);
        bus.fir_in_ready_i = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        bus.fir_in_ready_i = 1'b0;
        check("mid_head", bus.fir_in_data_o, 32'h208);
        xfer(1'b1, A_DIN, 32'h2AA, 4'hF, 1'b1, d, a, e);
        check("mid_pp_ack", {31'b0, a}, 32'd1);
        rd_chk("mid_pp_status", A_STATUS, 32'h0008_0008);

        // Partial-select DIN write, DIN read, unmapped access
        xfer(1'b1, A_DIN, 32'hDEAD, 4'h3, 1'b0, d, a, e);
        check("part_err", {31'b0, e}, 32'd1);
        check("part_ack", {31'b0, a}, 32'd0);
        rd_chk("part_status", A_STATUS, 32'h0008_0008);
        rd_chk("din_read", A_DIN, 32'h0);
        wr(A_UNMAP, 32'hFFFF_FFFF);
        rd_chk("unmap_read", A_UNMAP, 32'h0);
        rd_chk("unmap_ctrl", A_CTRL, 32'h5);

        // Fill both FIFOs, then flush
        for (int i = 0; i < 8; i++) wr(A_DIN, 32'h400 + i);
        for (int k = 0; k < 20; k++) begin
            bus.fir_out_valid_i = 1'b1;
            bus.fir_out_data_i  = 32'h300 + k;
            @(posedge clk); #1;
        end
        bus.fir_out_valid_i = 1'b0;
        check("out_full_ready", {31'b0, bus.fir_out_ready_o}, 32'd0);
        rd_chk("both_full_status", A_STATUS, 32'h0005_1010);
        rd_chk("dout_first", A_DOUT, 32'h300);
        wr(A_CTRL, 32'h3);
        check("flush_in_valid", {31'b0, bus.fir_in_valid_o}, 32'd0);
        check("flush_out_ready", {31'b0, bus.fir_out_ready_o}, 32'd1);
        rd_chk("flush_status", A_STATUS, 32'h000A_0000);
        rd_chk("flush_ctrl", A_CTRL, 32'h1);

        // Reset asserted while a write response is on the bus
        wr(A_CTRL, 32'h5);
        wr(A_DIN, 32'h77);
        bus.fir_out_valid_i = 1'b1;
        bus.fir_out_data_i  = 32'h99;
        @(posedge clk); #1;
        bus.fir_out_valid_i = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_int", {31'b0, int_o}, 32'd1);
        check("pre_rst_valid", {31'b0, bus.fir_in_valid_o}, 32'd1);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = A_DIN;
        bus.wb_dat_i = 32'hAB;
        bus.wb_sel_i = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'b0, bus.wb_ack_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ack",       {31'b0, bus.wb_ack_o},        32'd0);
        check("mid_rst_err",       {31'b0, bus.wb_err_o},        32'd0);
        check("mid_rst_dat",       bus.wb_dat_o,                 32'd0);
        check("mid_rst_int",       {31'b0, int_o},               32'd0);
        check("mid_rst_in_valid",  {31'b0, bus.fir_in_valid_o},  32'd0);
        check("mid_rst_out_ready", {31'b0, bus.fir_out_ready_o}, 32'd0);
        check("mid_rst_in_data",   bus.fir_in_data_o,            32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'h0;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("post_rst_status", A_STATUS, 32'h000A_0000);
        rd_chk("post_rst_ctrl", A_CTRL, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
